// File: rtl/adq_memory_if.sv
// rtl/adq_memory_if.sv - shared address/data bus between the ADQ front end and the word memory
interface adq_memory_if #(
    parameter int DATA_W = 64,
    parameter int ADD_S  = 5
);
    logic [DATA_W-1:0] data_in;
    logic [ADD_S-1:0]  add;
    logic              wr;
    logic [DATA_W-1:0] data_out;

    modport master (
        output data_in,
        output add,
        output wr,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  add,
        input  wr,
        output data_out
    );
endinterface

// File: rtl/adq_memory.sv
// rtl/adq_memory.sv - single-port RAM with registered read, cleared in full by async reset
module adq_memory #(
    parameter int DATA_W = 64,
    parameter int ADD_S  = 5
) (
    input  logic            clk,
    input  logic            rst,
    adq_memory_if.slave     bus
);
    localparam int DEPTH = 1 << ADD_S;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] data_out_d;

    // Storage is flops rather than a RAM macro so reset can clear every word at once.
    always_comb begin
        mem_d      = mem_q;
        data_out_d = data_out_q;
        if (bus.wr) begin
            mem_d[bus.add] = bus.data_in;
        end else begin
            data_out_d = mem_q[bus.add];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_adq_memory.sv
// tb/tb_adq_memory.sv - table and scoreboard driven check of adq_memory
module tb_adq_memory;
    localparam int DATA_W = 64;
    localparam int ADD_S  = 5;
    localparam int DEPTH  = 1 << ADD_S;

    logic clk;
    logic rst;

    adq_memory_if #(.DATA_W(DATA_W), .ADD_S(ADD_S)) bus ();

    adq_memory #(.DATA_W(DATA_W), .ADD_S(ADD_S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                wr;
        logic [ADD_S-1:0]  add;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] exp_out;
    } vec_t;

    int checks;
    int errors;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mdl_mem [DEPTH];
    logic [DATA_W-1:0] mdl_out;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        mdl_out = '0;
    endtask

    // One bus cycle: drive at negedge, sample 1 ns after the capturing edge.
    task automatic cycle(input bit w, input logic [ADD_S-1:0] a,
                         input logic [DATA_W-1:0] d, input string name);
        @(negedge clk);
        bus.wr      = w;
        bus.add     = a;
        bus.data_in = d;
        if (w) mdl_mem[a] = d;
        else   mdl_out = mdl_mem[a];
        exp_q.push_back(mdl_out);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check(name, bus.data_out, exp_q.pop_front());
        end
    endtask

    task automatic vec_cycle(input vec_t v, input string name);
        logic [DATA_W-1:0] dummy;
        @(negedge clk);
        bus.wr      = v.wr;
        bus.add     = v.add;
        bus.data_in = v.din;
        if (v.wr) mdl_mem[v.add] = v.din;
        else      mdl_out = mdl_mem[v.add];
        exp_q.push_back(v.exp_out);
        @(posedge clk);
        #1;
        dummy = exp_q.pop_front();
        check(name, bus.data_out, dummy);
    endtask

    // Reset pulse entirely between two rising edges; checks the asynchronous clear.
    task automatic rst_pulse(input string name);
        @(negedge clk);
        bus.wr = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check(name, bus.data_out, '0);
        mdl_clear();
        #1;
        rst = 1'b1;
    endtask

    vec_t vecs [8];

    initial begin
        checks = 0;
        errors = 0;
        mdl_clear();
        rst         = 1'b0;
        bus.wr      = 1'b0;
        bus.add     = '0;
        bus.data_in = '0;

        vecs[0] = '{1'b1, 5'h00, 64'h0000_FFFF_FFFF_0000, 64'h0};
        vecs[1] = '{1'b0, 5'h00, 64'h0,                   64'h0000_FFFF_FFFF_0000};
        vecs[2] = '{1'b1, 5'h02, 64'h5555_FFFF_0000_2222, 64'h0000_FFFF_FFFF_0000};
        vecs[3] = '{1'b0, 5'h02, 64'h0,                   64'h5555_FFFF_0000_2222};
        vecs[4] = '{1'b0, 5'h00, 64'h0,                   64'h0000_FFFF_FFFF_0000};
        vecs[5] = '{1'b1, 5'h1F, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_FFFF_FFFF_0000};
        vecs[6] = '{1'b0, 5'h1F, 64'h0,                   64'hDEAD_BEEF_CAFE_F00D};
        vecs[7] = '{1'b0, 5'h00, 64'h0,                   64'h0000_FFFF_FFFF_0000};

        #3;
        check("reset_out", bus.data_out, '0);
        @(negedge clk);
        rst = 1'b1;

        rst_pulse("pulse1_out");
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, a[ADD_S-1:0], '0, "read_cleared");

        for (int i = 0; i < 8; i++) vec_cycle(vecs[i], $sformatf("vec%0d", i));

        // Mid-cycle wiggle on the inputs must not be sampled.
        @(posedge clk);
        #1;
        bus.wr = 1'b1; bus.add = 5'h05; bus.data_in = 64'hBAD0_BAD0_BAD0_BAD0;
        #2;
        bus.wr = 1'b0; bus.add = 5'h1F;
        cycle(1'b0, 5'h05, '0, "no_midcycle_write");

        cycle(1'b1, 5'h03, 64'h1234_5678_9ABC_DEF0, "wr3");
        cycle(1'b1, 5'h11, 64'hFFFF_0000_FFFF_0000, "wr11");
        cycle(1'b0, 5'h03, '0, "rd3_before_rst");
        rst_pulse("pulse2_out");
        cycle(1'b0, 5'h03, '0, "rd3_after_rst");
        cycle(1'b0, 5'h11, '0, "rd11_after_rst");
        cycle(1'b0, 5'h1F, '0, "rd1f_after_rst");
        cycle(1'b0, 5'h00, '0, "rd0_after_rst");

        for (int a = 0; a < DEPTH; a++) begin
            logic [DATA_W-1:0] pat;
            pat = DATA_W'(a) * 64'h0101_0101_0101_0101;
            cycle(1'b1, a[ADD_S-1:0], pat, "alt_wr");
            cycle(1'b0, a[ADD_S-1:0], '0, "alt_rd");
        end
        for (int a = DEPTH - 1; a >= 0; a -= 7) cycle(1'b0, a[ADD_S-1:0], '0, "sweep_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
